tc_pl_chips_adc: RTL and testbench



---
 rtl/tc_pl_chips_pkg.sv | 20 ++
 rtl/tc_pl_chips_adc_trk.sv | 47 ++++
 rtl/tc_pl_chips_adc.sv | 171 +++++++++++++++++
 tb/tb_tc_pl_chips_adc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pl_chips_pkg.sv
// Shared definitions for the Tc_PL_chips_* blocks: default widths and ADC averager states.
// Pure declarations; no logic, latency or flow control of its own.
package tc_pl_chips_pkg;

    localparam int ADC0_0_DEF = 14;
    localparam int AVG0_0_DEF = 8;
    localparam int AVG0_1_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACC    = 2'd2,
        ST_DONE   = 2'd3
    } adc_st_e;

    function automatic logic [3:0] clamp_log2(input logic [3:0] req, input logic [3:0] lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/tc_pl_chips_adc_trk.sv
// Window max/min/overrange trackers; *_nxt outputs are combinational views including the current sample.
// Registered state updates every cycle; no backpressure (sample valid every cycle).
module tc_pl_chips_adc_trk #(
    parameter int W = 14
) (
    input  logic         clk125,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] smp,
    input  logic         smp_of,
    output logic [W-1:0] max_nxt,
    output logic [W-1:0] min_nxt,
    output logic         of_nxt
);
    logic [W-1:0] max_q, max_d, min_q, min_d;
    logic         of_q, of_d;
    logic [W-1:0] max_base, min_base;
    logic         of_base;

    // clr and en together restart the window with the current sample already counted
    always_comb begin
        max_base = clr ? '0 : max_q;
        min_base = clr ? '1 : min_q;
        of_base  = clr ? 1'b0 : of_q;
        max_d    = (en && (smp > max_base)) ? smp : max_base;
        min_d    = (en && (smp < min_base)) ? smp : min_base;
        of_d     = of_base | (en & smp_of);
    end

    always_ff @(posedge clk125) begin
        if (rst) begin
            max_q <= '0;
            min_q <= '1;
            of_q  <= 1'b0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
            of_q  <= of_d;
        end
    end

    assign max_nxt = max_d;
    assign min_nxt = min_d;
    assign of_nxt  = of_d;

endmodule

// File: rtl/tc_pl_chips_adc.sv
// ADC window averager: settle, accumulate 2^n registered samples, strobe mean/max/min/overrange.
// Result 1 cycle after the last window sample; no backpressure, results hold until the next strobe.
module tc_pl_chips_adc
    import tc_pl_chips_pkg::*;
#(
    parameter int ADC0_0 = ADC0_0_DEF,
    parameter int AVG0_0 = AVG0_0_DEF,
    parameter int AVG0_1 = AVG0_1_DEF
) (
    input  logic              clk125,
    input  logic              rst,
    input  logic [ADC0_0-1:0] Gc_adc_data,
    input  logic              Gc_adc_of,
    input  logic [3:0]        avg_log2,
    input  logic              avg_cont,
    input  logic              avg_start,
    output logic              avg_busy,
    output logic              avg_done,
    output logic [ADC0_0-1:0] avg_data,
    output logic              avg_of,
    output logic [ADC0_0-1:0] avg_max,
    output logic [ADC0_0-1:0] avg_min
);
    localparam int AW = ADC0_0 + AVG0_0;
    localparam int CW = ((AVG0_0 + 1) > $clog2(AVG0_1 + 1)) ? (AVG0_0 + 1) : $clog2(AVG0_1 + 1);
    localparam logic [3:0]    N_MAX    = 4'(AVG0_0);
    localparam logic [CW-1:0] SET_LAST = CW'(AVG0_1 - 1);

    adc_st_e           state_q, state_d;
    logic [3:0]        n_q, n_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [ADC0_0-1:0] smp_q, smp_d;
    logic              smp_of_q, smp_of_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADC0_0-1:0] data_q, data_d;
    logic              of_q, of_d;
    logic [ADC0_0-1:0] max_q, max_d;
    logic [ADC0_0-1:0] min_q, min_d;

    logic              acc_clr, acc_en, take;
    logic [CW-1:0]     win_last;
    logic [ADC0_0-1:0] trk_max, trk_min;
    logic              trk_of;

    tc_pl_chips_adc_trk #(.W(ADC0_0)) u_trk (
        .clk125  (clk125),
        .rst     (rst),
        .clr     (acc_clr),
        .en      (acc_en),
        .smp     (smp_q),
        .smp_of  (smp_of_q),
        .max_nxt (trk_max),
        .min_nxt (trk_min),
        .of_nxt  (trk_of)
    );

    assign win_last = (CW'(1) << n_q) - CW'(1);

    always_comb begin
        smp_d    = Gc_adc_data;
        smp_of_d = Gc_adc_of;
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        of_d     = of_q;
        max_d    = max_q;
        min_d    = min_q;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        take     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                acc_clr = 1'b1;
                if (avg_start) begin
                    n_d     = clamp_log2(avg_log2, N_MAX);
                    cnt_d   = '0;
                    state_d = (AVG0_1 == 0) ? ST_ACC : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                acc_clr = 1'b1;
                if (cnt_q == SET_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ACC: begin
                acc_en = 1'b1;
                if (cnt_q == win_last) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    take    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // Continuous mode counts the DONE cycle as the first sample of the next window,
                // so strobes repeat every 2^n cycles.
                acc_clr = 1'b1;
                if (avg_cont) begin
                    acc_en = 1'b1;
                    if (win_last == '0) begin
                        take = 1'b1;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        acc_d = (acc_clr ? '0 : acc_q) + (acc_en ? AW'(smp_q) : '0);

        if (take) begin
            data_d = ADC0_0'(acc_d >> n_q);
            of_d   = trk_of;
            max_d  = trk_max;
            min_d  = trk_min;
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_ACC);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk125) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            smp_q    <= '0;
            smp_of_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            of_q     <= 1'b0;
            max_q    <= '0;
            min_q    <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            smp_q    <= smp_d;
            smp_of_q <= smp_of_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data_q   <= data_d;
            of_q     <= of_d;
            max_q    <= max_d;
            min_q    <= min_d;
        end
    end

    assign avg_busy = busy_q;
    assign avg_done = done_q;
    assign avg_data = data_q;
    assign avg_of   = of_q;
    assign avg_max  = max_q;
    assign avg_min  = min_q;

endmodule

// File: tb/tb_tc_pl_chips_adc.sv
// Bench for tc_pl_chips_adc: directed scenarios plus random traffic against a window-level model.
// The model keeps raw input history and recomputes each window's mean/max/min/overrange directly.
module tb_tc_pl_chips_adc;

    localparam int S    = 4;
    localparam int NMAX = 8;
    localparam int HMAX = 8192;

    logic        clk125 = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] Gc_adc_data = '0;
    logic        Gc_adc_of = 1'b0;
    logic [3:0]  avg_log2 = '0;
    logic        avg_cont = 1'b0;
    logic        avg_start = 1'b0;
    logic        avg_busy, avg_done, avg_of;
    logic [13:0] avg_data, avg_max, avg_min;

    tc_pl_chips_adc dut (
        .clk125      (clk125),
        .rst         (rst),
        .Gc_adc_data (Gc_adc_data),
        .Gc_adc_of   (Gc_adc_of),
        .avg_log2    (avg_log2),
        .avg_cont    (avg_cont),
        .avg_start   (avg_start),
        .avg_busy    (avg_busy),
        .avg_done    (avg_done),
        .avg_data    (avg_data),
        .avg_of      (avg_of),
        .avg_max     (avg_max),
        .avg_min     (avg_min)
    );

    always #5 clk125 = ~clk125;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: raw history plus the current window's sample span and strobe cycle.
    logic [13:0] raw_mem [0:HMAX-1];
    bit          of_mem  [0:HMAX-1];
    int          cyc = 0;
    bit          m_act = 0;
    int          m_beg, m_f, m_done, m_n;
    logic [13:0] e_data = '0, e_max = '0, e_min = '0;
    logic        e_of = 1'b0;

    task automatic step(input logic [13:0] d, input logic o, input logic [3:0] l2,
                        input logic c, input logic s, input logic r);
        bit          e_done, e_busy;
        longint      sum;
        logic [13:0] mx, mn;
        bit          ov;
        @(posedge clk125);
        #1;
        Gc_adc_data = d;
        Gc_adc_of   = o;
        avg_log2    = l2;
        avg_cont    = c;
        avg_start   = s;
        rst         = r;
        raw_mem[cyc] = r ? 14'd0 : d;
        of_mem[cyc]  = r ? 1'b0 : o;
        @(negedge clk125);

        e_done = m_act && (cyc == m_done);
        e_busy = m_act && (cyc > m_beg) && (cyc < m_done);
        if (e_done) begin
            sum = 0; mx = 14'h0; mn = 14'h3FFF; ov = 0;
            for (int i = 0; i < (1 << m_n); i++) begin
                sum += longint'(raw_mem[m_f + i]);
                if (raw_mem[m_f + i] > mx) mx = raw_mem[m_f + i];
                if (raw_mem[m_f + i] < mn) mn = raw_mem[m_f + i];
                ov |= of_mem[m_f + i];
            end
            e_data = 14'(sum >> m_n);
            e_max  = mx;
            e_min  = mn;
            e_of   = ov;
        end
        chk("done", {31'd0, avg_done}, {31'd0, e_done});
        chk("busy", {31'd0, avg_busy}, {31'd0, e_busy});
        chk("data", {18'd0, avg_data}, {18'd0, e_data});
        chk("max",  {18'd0, avg_max},  {18'd0, e_max});
        chk("min",  {18'd0, avg_min},  {18'd0, e_min});
        chk("of",   {31'd0, avg_of},   {31'd0, e_of});

        if (r) begin
            m_act = 0;
            e_data = '0; e_max = '0; e_min = '0; e_of = 1'b0;
        end else if (e_done) begin
            if (c) begin
                m_f    = cyc - 1;
                m_beg  = cyc;
                m_done = m_f + (1 << m_n) + 1;
            end else begin
                m_act = 0;
            end
        end else if (!m_act && s) begin
            m_act  = 1;
            m_n    = (int'(l2) > NMAX) ? NMAX : int'(l2);
            m_beg  = cyc;
            m_f    = cyc + S;
            m_done = m_f + (1 << m_n) + 1;
        end
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(14'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [13:0] keep;
        logic        cont_r;

        for (int i = 0; i < 3; i++) begin
            step(14'h1234, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1);
            chk("rst_busy", {31'd0, avg_busy}, 32'd0);
            chk("rst_min", {18'd0, avg_min}, 32'd0);
        end
        idle(2);

        // constant 0x1000, n=2: strobe 9 cycles after start
        for (int j = 0; j <= 9; j++) begin
            step(14'h1000, 1'b0, 4'd2, 1'b0, (j == 0), 1'b0);
            if (j == 8) chk("c1000_early", {31'd0, avg_done}, 32'd0);
            if (j == 9) begin
                chk("c1000_done", {31'd0, avg_done}, 32'd1);
                chk("c1000_data", {18'd0, avg_data}, 32'h1000);
                chk("c1000_max", {18'd0, avg_max}, 32'h1000);
                chk("c1000_min", {18'd0, avg_min}, 32'h1000);
                chk("c1000_of", {31'd0, avg_of}, 32'd0);
            end
        end
        idle(2);

        // ramp: window sees 5..12
        step(14'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j <= 13; j++) begin
            step(14'(j + 1), 1'b0, 4'd3, 1'b0, (j == 0), 1'b0);
            if (j == 13) begin
                chk("ramp_done", {31'd0, avg_done}, 32'd1);
                chk("ramp_data", {18'd0, avg_data}, 32'd8);
                chk("ramp_min", {18'd0, avg_min}, 32'd5);
                chk("ramp_max", {18'd0, avg_max}, 32'd12);
            end
        end
        idle(2);

        // full-scale, log2 request 15 clamps to 8
        for (int j = 0; j <= 261; j++) begin
            step(14'h3FFF, 1'b0, 4'd15, 1'b0, (j == 0), 1'b0);
            if (j == 260) chk("clamp_early", {31'd0, avg_done}, 32'd0);
            if (j == 261) begin
                chk("clamp_done", {31'd0, avg_done}, 32'd1);
                chk("clamp_data", {18'd0, avg_data}, 32'h3FFF);
            end
        end
        idle(2);

        // overrange inside the window, then only during settle
        for (int j = 0; j <= 9; j++) begin
            step(14'(100 + j), (j == 5), 4'd2, 1'b0, (j == 0), 1'b0);
            if (j == 9) chk("of_in_win", {31'd0, avg_of}, 32'd1);
        end
        idle(2);
        for (int j = 0; j <= 9; j++) begin
            step(14'(200 + j), (j == 2), 4'd2, 1'b0, (j == 0), 1'b0);
            if (j == 9) chk("of_settle", {31'd0, avg_of}, 32'd0);
        end
        idle(2);

        // repeated start and log2 change while busy are ignored
        for (int j = 0; j <= 10; j++) begin
            step(14'(j * 7), 1'b0, (j < 3) ? 4'd2 : 4'd5, 1'b0, (j == 0 || j == 3 || j == 6), 1'b0);
            if (j == 9) chk("busy_start_done", {31'd0, avg_done}, 32'd1);
            if (j == 10) chk("busy_start_idle", {31'd0, avg_busy}, 32'd0);
        end
        idle(2);

        // continuous n=1: strobes every 2 cycles, cont drops mid-window
        for (int j = 0; j <= 14; j++) begin
            step(14'($urandom_range(0, 16383)), 1'b0, 4'd1, (j <= 11), (j == 0), 1'b0);
            if (j == 7 || j == 9 || j == 11 || j == 13) chk("cont_strobe", {31'd0, avg_done}, 32'd1);
            if (j == 8 || j == 10 || j == 12) chk("cont_gap", {31'd0, avg_done}, 32'd0);
            if (j == 14) chk("cont_stop", {31'd0, avg_busy | avg_done}, 32'd0);
        end
        idle(2);

        // reset mid-ACC aborts; next start (n=0) accepted straight away
        keep = '0;
        for (int j = 0; j <= 14; j++) begin
            step(14'($urandom_range(1, 16383)), 1'b0, (j == 8) ? 4'd0 : 4'd3, 1'b0,
                 (j == 0 || j == 8), (j == 7));
            if (j == 12) keep = raw_mem[cyc - 1];
            if (j == 8) begin
                chk("rst_mid_busy", {31'd0, avg_busy}, 32'd0);
                chk("rst_mid_data", {18'd0, avg_data}, 32'd0);
                chk("rst_mid_max", {18'd0, avg_max}, 32'd0);
            end
            if (j == 13) chk("rst_mid_nodone", {31'd0, avg_done}, 32'd0);
            if (j == 14) begin
                chk("n0_done", {31'd0, avg_done}, 32'd1);
                chk("n0_data", {18'd0, avg_data}, {18'd0, keep});
                chk("n0_max", {18'd0, avg_max}, {18'd0, keep});
                chk("n0_min", {18'd0, avg_min}, {18'd0, keep});
            end
        end
        idle(2);

        cont_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) cont_r = ~cont_r;
            step(14'($urandom_range(0, 16383)), ($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 9)), cont_r, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 399) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
